// File: rtl/adc_frame_unpacker.sv
// Frame-aligns the 4-lane x 64-bit ADC capture shift register and drains each
// captured frame as sixteen 16-bit channel samples over a valid/ready stream.

module adc_frame_lane (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        load,
  input  logic [63:0] din,
  input  logic [1:0]  sel,
  output logic [15:0] word
);
  logic [3:0][15:0] data;

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST)     data <= '0;
    else if (load) data <= din;

  // word 0 is the MSB word of the lane (oldest bits on the wire)
  assign word = data[2'd3 - sel];
endmodule

module adc_frame_unpacker (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        FRAME_START,
  input  logic [63:0] DATA_IN [3:0],
  output logic [15:0] SAMPLE,
  output logic [3:0]  CH_IDX,
  output logic        SAMPLE_VALID,
  input  logic        SAMPLE_READY,
  output logic        OVERRUN,
  input  logic        CLR_OVERRUN
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [6:0]       bit_cnt;
  logic             cap_req, full, hs, last_hs, load, drop;
  logic [3:0]       rd_idx, rd_inc;
  logic [3:0][15:0] lane_word;
  logic [15:0]      sample_nxt;

  // Framer: bit_cnt == 64 means DATA_IN holds the whole frame this cycle
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (FRAME_START) begin
            state   <= SHIFT;
            bit_cnt <= 7'd1;
          end
        SHIFT:
          if (FRAME_START) bit_cnt <= 7'd1;
          else if (bit_cnt == 7'd64) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end else bit_cnt <= bit_cnt + 7'd1;
        default: state <= IDLE;
      endcase
    end

  assign cap_req = (state == SHIFT) && (bit_cnt == 7'd64);
  assign hs      = full && SAMPLE_READY;
  assign last_hs = hs && (rd_idx == 4'd15);
  assign load    = cap_req && (!full || last_hs);
  assign drop    = cap_req && !load;
  assign rd_inc  = rd_idx + 4'd1;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    adc_frame_lane u_lane (
      .CLK  (CLK),
      .nRST (nRST),
      .load (load),
      .din  (DATA_IN[i]),
      .sel  (rd_inc[1:0]),
      .word (lane_word[i])
    );
  end

  // SAMPLE is registered from the next read position so it never lags rd_idx
  always_comb begin
    sample_nxt = SAMPLE;
    if (load)    sample_nxt = DATA_IN[0][63:48];
    else if (hs) sample_nxt = lane_word[rd_inc[3:2]];
  end

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      full    <= 1'b0;
      rd_idx  <= '0;
      SAMPLE  <= '0;
      OVERRUN <= 1'b0;
    end else begin
      if (load) begin
        full   <= 1'b1;
        rd_idx <= '0;
      end else if (hs) begin
        rd_idx <= rd_inc;
        if (rd_idx == 4'd15) full <= 1'b0;
      end
      SAMPLE <= sample_nxt;
      if (drop)             OVERRUN <= 1'b1;
      else if (CLR_OVERRUN) OVERRUN <= 1'b0;
    end

  assign CH_IDX       = rd_idx;
  assign SAMPLE_VALID = full;
endmodule

// File: tb/tb_adc_frame_unpacker.sv
// Scoreboard bench for adc_frame_unpacker: a serial shift-register model feeds
// DATA_IN; a negedge monitor pops expected samples on every handshake.

module tb_adc_frame_unpacker;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        FRAME_START = 1'b0;
  logic [63:0] sr [3:0];
  logic [3:0]  ser = '0;
  logic [15:0] SAMPLE;
  logic [3:0]  CH_IDX;
  logic        SAMPLE_VALID;
  logic        SAMPLE_READY = 1'b1;
  logic        OVERRUN;
  logic        CLR_OVERRUN = 1'b0;

  typedef struct packed {
    logic [3:0]  ch;
    logic [15:0] s;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   tgl = 1'b0;

  adc_frame_unpacker dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .FRAME_START  (FRAME_START),
    .DATA_IN      (sr),
    .SAMPLE       (SAMPLE),
    .CH_IDX       (CH_IDX),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_READY (SAMPLE_READY),
    .OVERRUN      (OVERRUN),
    .CLR_OVERRUN  (CLR_OVERRUN)
  );

  always #5 CLK = ~CLK;

  // ADC capture shift register: MSB of each lane is the oldest bit
  always @(posedge CLK)
    for (int i = 0; i < 4; i++) sr[i] <= {sr[i][62:0], ser[i]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample word w of lane `lane` in frame `tag`: {tag*4+lane, w+1, w+1, w+1}
  function automatic logic [15:0] exp_word(input int tag, input int lane, input int w);
    logic [3:0] t, n;
    t = 4'(tag * 4 + lane);
    n = 4'(w + 1);
    return {t, n, n, n};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    if (tgl) SAMPLE_READY = ~SAMPLE_READY;
  endtask

  task automatic send_frame(input int tag, input int nbits, input bit push, input int rdy_at);
    logic [63:0] fr [4];
    for (int l = 0; l < 4; l++) begin
      fr[l] = {exp_word(tag, l, 0), exp_word(tag, l, 1), exp_word(tag, l, 2), exp_word(tag, l, 3)};
      if (push)
        for (int w = 0; w < 4; w++) q.push_back({4'(l * 4 + w), exp_word(tag, l, w)});
    end
    for (int b = 0; b < nbits; b++) begin
      FRAME_START = (b == 0);
      for (int l = 0; l < 4; l++) ser[l] = fr[l][63 - b];
      if (b == rdy_at) SAMPLE_READY = 1'b1;
      tick();
    end
    FRAME_START = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 600) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(q.size()), 32'd0);
    chk("drain_valid_low", 32'(SAMPLE_VALID), 32'd0);
  endtask

  // Monitor: handshake pops, and stalled outputs must hold
  logic        stall = 1'b0;
  logic [15:0] held_s;
  logic [3:0]  held_ch;
  always @(negedge CLK) begin
    if (!nRST) stall = 1'b0;
    else begin
      if (stall) begin
        chk("stall_valid", 32'(SAMPLE_VALID), 32'd1);
        chk("stall_hold", 32'({CH_IDX, SAMPLE}), 32'({held_ch, held_s}));
      end
      if (SAMPLE_VALID && SAMPLE_READY) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got ch=%0d sample=%h expected none at %0t", CH_IDX, SAMPLE, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sample", 32'({CH_IDX, SAMPLE}), 32'({e.ch, e.s}));
        end
      end
      stall   = SAMPLE_VALID && !SAMPLE_READY;
      held_s  = SAMPLE;
      held_ch = CH_IDX;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_sample", 32'(SAMPLE), 32'd0);
    chk("rst_ch", 32'(CH_IDX), 32'd0);
    chk("rst_valid", 32'(SAMPLE_VALID), 32'd0);
    chk("rst_overrun", 32'(OVERRUN), 32'd0);
    tick();
    nRST = 1'b1;
    tick();
    tick();

    // 1. Single frame, exact first/last timing
    send_frame(0, 64, 1'b1, -1);
    chk("t1_valid_e64", 32'(SAMPLE_VALID), 32'd0);
    tick();
    chk("t1_valid_e65", 32'(SAMPLE_VALID), 32'd1);
    chk("t1_ch_e65", 32'(CH_IDX), 32'd0);
    chk("t1_sample_e65", 32'(SAMPLE), 32'h0111);
    repeat (15) tick();
    chk("t1_ch_e80", 32'(CH_IDX), 32'd15);
    chk("t1_sample_e80", 32'(SAMPLE), 32'h3444);
    tick();
    chk("t1_valid_e81", 32'(SAMPLE_VALID), 32'd0);
    wait_drain();

    // 2. Three back-to-back frames
    send_frame(1, 64, 1'b1, -1);
    send_frame(2, 64, 1'b1, -1);
    send_frame(3, 64, 1'b1, -1);
    wait_drain();
    chk("t2_overrun", 32'(OVERRUN), 32'd0);

    // 3a. 50% READY toggling
    tgl = 1'b1;
    send_frame(8, 64, 1'b1, -1);
    wait_drain();
    tgl = 1'b0;
    // 3b. READY low 70 cycles after capture: second frame dropped
    SAMPLE_READY = 1'b0;
    send_frame(9, 64, 1'b1, -1);
    send_frame(10, 64, 1'b0, -1);
    tick();
    chk("t3_overrun_set", 32'(OVERRUN), 32'd1);
    repeat (6) tick();
    SAMPLE_READY = 1'b1;
    wait_drain();
    chk("t3_overrun_sticky", 32'(OVERRUN), 32'd1);
    CLR_OVERRUN = 1'b1;
    tick();
    CLR_OVERRUN = 1'b0;
    chk("t3_overrun_clr", 32'(OVERRUN), 32'd0);

    // 4. Final handshake of frame 11 coincides with capture of frame 12
    SAMPLE_READY = 1'b0;
    send_frame(11, 64, 1'b1, -1);
    send_frame(12, 64, 1'b1, 49);
    tick();
    chk("t4_valid", 32'(SAMPLE_VALID), 32'd1);
    chk("t4_ch", 32'(CH_IDX), 32'd0);
    chk("t4_sample", 32'(SAMPLE), 32'(exp_word(12, 0, 0)));
    chk("t4_overrun", 32'(OVERRUN), 32'd0);
    wait_drain();
    chk("t4_overrun_end", 32'(OVERRUN), 32'd0);

    // 5. Restart at bit_cnt 30, then reset mid-drain
    SAMPLE_READY = 1'b1;
    send_frame(14, 30, 1'b0, -1);
    send_frame(13, 64, 1'b1, -1);
    tick();
    repeat (7) tick();
    chk("t5_ch7", 32'(CH_IDX), 32'd7);
    chk("t5_overrun", 32'(OVERRUN), 32'd0);
    nRST = 1'b0;
    #1;
    chk("t5_rst_sample", 32'(SAMPLE), 32'd0);
    chk("t5_rst_ch", 32'(CH_IDX), 32'd0);
    chk("t5_rst_valid", 32'(SAMPLE_VALID), 32'd0);
    chk("t5_rst_overrun", 32'(OVERRUN), 32'd0);
    q.delete();
    repeat (3) tick();
    nRST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t5_no_output", 32'(SAMPLE_VALID), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
